wb_arbiter_4x1: RTL and testbench

Round-robin Wishbone arbiter that shares one slave-side Wishbone port among four requesting masters. It sits between up to four bus masters (CPU, DMA, debug, etc.) and one master port of a `wb_interconnect_*` instance or a single peripheral. Ownership is granted per bus cycle and held while the owner keeps CYC asserted. An optional watchdog terminates stalled transfers with ERR so that one hung slave cannot lock out the other masters.

---
 rtl/wb_arbiter_4x1.sv | 185 ++++++++++++++++++
 tb/tb_wb_arbiter_4x1.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_4x1.sv
// wb_arbiter_4x1: round-robin arbiter sharing one Wishbone slave port among four masters,
// with an optional stall watchdog that terminates hung transfers with ERR.
`default_nettype none

module wb_arbiter_4x1 #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  // requesting masters, index = master number
  input  logic [3:0]                 m_cyc,
  input  logic [3:0]                 m_stb,
  input  logic [3:0]                 m_we,
  input  logic [WB_ADDR_WIDTH-1:0]   m_adr   [4],
  input  logic [WB_DATA_WIDTH-1:0]   m_dat_w [4],
  input  logic [WB_DATA_WIDTH/8-1:0] m_sel   [4],
  input  logic [2:0]                 m_cti   [4],
  input  logic [1:0]                 m_bte   [4],
  output logic [3:0]                 m_ack,
  output logic [3:0]                 m_err,
  output logic [WB_DATA_WIDTH-1:0]   m_dat_r [4],
  // shared downstream port
  output logic                       s0_cyc,
  output logic                       s0_stb,
  output logic                       s0_we,
  output logic [WB_ADDR_WIDTH-1:0]   s0_adr,
  output logic [WB_DATA_WIDTH-1:0]   s0_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0] s0_sel,
  output logic [2:0]                 s0_cti,
  output logic [1:0]                 s0_bte,
  input  logic                       s0_ack,
  input  logic                       s0_err,
  input  logic [WB_DATA_WIDTH-1:0]   s0_dat_r,
  output logic [3:0]                 grant,
  output logic                       timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] grant_q, grant_d;

  logic       own_cyc;
  logic       own_stb;
  logic       arb_valid;
  logic [1:0] arb_idx;
  logic [1:0] cand;
  logic       rearb;
  logic       wd_fire;

  assign own_cyc = m_cyc[owner_q];
  assign own_stb = m_stb[owner_q];

  // Search starts one past the last owner and wraps back to it.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!arb_valid && m_cyc[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
      logic             wd_stall;

      assign wd_stall = (state_q == ST_GRANT) && own_cyc && own_stb && !s0_ack && !s0_err;
      assign wd_fire  = wd_stall && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      always_comb begin
        wd_cnt_d = '0;
        if (wd_stall) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wd_cnt_q <= '0;
        end else begin
          wd_cnt_q <= wd_cnt_d;
        end
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    rearb   = 1'b0;
    case (state_q)
      ST_IDLE:  rearb = 1'b1;
      ST_GRANT: begin
        if (!own_cyc) begin
          rearb = 1'b1;
        end else if (wd_fire) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: rearb = !own_cyc;
      default:  state_d = ST_IDLE;
    endcase
    if (rearb) begin
      if (arb_valid) begin
        state_d = ST_GRANT;
        owner_d = arb_idx;
        last_d  = arb_idx;
        grant_d = 4'b0001 << arb_idx;
      end else begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Downstream and response paths are pure muxes; nothing passes outside GRANT.
  always_comb begin
    s0_cyc   = 1'b0;
    s0_stb   = 1'b0;
    s0_we    = 1'b0;
    s0_adr   = '0;
    s0_dat_w = '0;
    s0_sel   = '0;
    s0_cti   = '0;
    s0_bte   = '0;
    m_ack    = 4'b0000;
    m_err    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_dat_r[i] = '0;
    end
    if (state_q == ST_GRANT) begin
      s0_cyc           = own_cyc;
      s0_stb           = own_cyc & own_stb;
      s0_we            = m_we[owner_q];
      s0_adr           = m_adr[owner_q];
      s0_dat_w         = m_dat_w[owner_q];
      s0_sel           = m_sel[owner_q];
      s0_cti           = m_cti[owner_q];
      s0_bte           = m_bte[owner_q];
      m_ack[owner_q]   = s0_ack;
      m_err[owner_q]   = s0_err | wd_fire;
      m_dat_r[owner_q] = s0_dat_r;
    end
  end

  assign grant   = grant_q;
  assign timeout = wd_fire;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_4x1.sv
// tb_wb_arbiter_4x1: scoreboard bench for the round-robin Wishbone arbiter.
`default_nettype none

module tb_wb_arbiter_4x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr   [4];
  logic [DW-1:0] m_dat_w [4];
  logic [3:0]    m_sel   [4];
  logic [2:0]    m_cti   [4];
  logic [1:0]    m_bte   [4];
  logic [3:0]    m_ack, m_err;
  logic [DW-1:0] m_dat_r [4];
  logic          s0_cyc, s0_stb, s0_we;
  logic [AW-1:0] s0_adr;
  logic [DW-1:0] s0_dat_w;
  logic [3:0]    s0_sel;
  logic [2:0]    s0_cti;
  logic [1:0]    s0_bte;
  logic          s0_ack, s0_err;
  logic [DW-1:0] s0_dat_r;
  logic [3:0]    grant;
  logic          timeout;

  int            checks   = 0;
  int            failures = 0;
  int            exp_grant_q[$];
  logic [AW-1:0] exp_adr_q[$];

  wb_arbiter_4x1 #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_cti   (m_cti),
    .m_bte   (m_bte),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_dat_r (m_dat_r),
    .s0_cyc  (s0_cyc),
    .s0_stb  (s0_stb),
    .s0_we   (s0_we),
    .s0_adr  (s0_adr),
    .s0_dat_w(s0_dat_w),
    .s0_sel  (s0_sel),
    .s0_cti  (s0_cti),
    .s0_bte  (s0_bte),
    .s0_ack  (s0_ack),
    .s0_err  (s0_err),
    .s0_dat_r(s0_dat_r),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: run did not finish within time budget");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [2:0] cti);
    m_cyc[i]   = cyc;
    m_stb[i]   = stb;
    m_we[i]    = we;
    m_adr[i]   = adr;
    m_dat_w[i] = 32'hA5A5_0000 | adr;
    m_sel[i]   = 4'hF;
    m_cti[i]   = cti;
    m_bte[i]   = 2'b00;
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    s0_ack   = 1'b0;
    s0_err   = 1'b0;
    s0_dat_r = '0;
    for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s0_ack = 1'b0; s0_err = 1'b0; s0_dat_r = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 3'b111);
    s0_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      failures++; $display("FAIL reset_grant: grant=%b timeout=%b required 0000/0", grant, timeout);
    end
    checks++;
    if (s0_cyc !== 1'b0 || s0_stb !== 1'b0 || s0_we !== 1'b0 || s0_adr !== '0 || s0_dat_w !== '0) begin
      failures++; $display("FAIL reset_s0: cyc=%b stb=%b we=%b adr=%h dat=%h required all 0",
                           s0_cyc, s0_stb, s0_we, s0_adr, s0_dat_w);
    end
    checks++;
    if (m_ack !== 4'b0 || m_err !== 4'b0 || m_dat_r[0] !== '0 || m_dat_r[3] !== '0) begin
      failures++; $display("FAIL reset_resp: ack=%b err=%b dat0=%h required 0", m_ack, m_err, m_dat_r[0]);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int idx;
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h40, 3'b000);
    m_dat_w[2] = 32'hA5A5_A5A5;
    exp_grant_q.push_back(2);
    exp_adr_q.push_back(32'h40);
    #1;
    checks++;
    if (s0_cyc !== 1'b0) begin
      failures++; $display("FAIL single_no_comb_path: s0_cyc=%b required 0", s0_cyc);
    end
    tick();
    idx = exp_grant_q.pop_front();
    checks++;
    if (grant !== (4'b0001 << idx) || s0_cyc !== 1'b1) begin
      failures++; $display("FAIL single_grant: grant=%b s0_cyc=%b required %b/1", grant, s0_cyc, 4'b0001 << idx);
    end
    checks++;
    if (s0_adr !== exp_adr_q.pop_front() || s0_dat_w !== 32'hA5A5_A5A5 || s0_we !== 1'b1) begin
      failures++; $display("FAIL single_mirror: adr=%h dat=%h we=%b required 40/a5a5a5a5/1", s0_adr, s0_dat_w, s0_we);
    end
    tick();
    checks++;
    if (m_ack !== 4'b0000) begin
      failures++; $display("FAIL single_early_ack: ack=%b required 0000", m_ack);
    end
    tick();
    s0_ack = 1'b1;
    s0_dat_r = 32'h1234_5678;
    #1;
    checks++;
    if (m_ack !== 4'b0100 || m_dat_r[2] !== 32'h1234_5678 || m_dat_r[0] !== '0) begin
      failures++; $display("FAIL single_ack: ack=%b dat2=%h dat0=%h required 0100/12345678/0",
                           m_ack, m_dat_r[2], m_dat_r[0]);
    end
    tick();
    s0_ack = 1'b0;
    set_m(2, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checks++;
    if (s0_cyc !== 1'b0) begin
      failures++; $display("FAIL single_release: s0_cyc=%b required 0", s0_cyc);
    end
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      failures++; $display("FAIL single_idle: grant=%b required 0000", grant);
    end
  endtask

  task automatic test_round_robin();
    int idx;
    int own;
    apply_reset();
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 3'b000);
    exp_grant_q.push_back(0); exp_grant_q.push_back(1); exp_grant_q.push_back(2);
    exp_grant_q.push_back(3); exp_grant_q.push_back(0);
    tick();
    for (int n = 0; n < 5; n++) begin
      idx = exp_grant_q.pop_front();
      exp_adr_q.push_back(32'h100 + 32'(idx));
      checks++;
      if (grant !== (4'b0001 << idx) || s0_cyc !== 1'b1) begin
        failures++; $display("FAIL rr_grant[%0d]: grant=%b s0_cyc=%b required %b/1", n, grant, s0_cyc, 4'b0001 << idx);
      end
      checks++;
      if (s0_adr !== exp_adr_q.pop_front()) begin
        failures++; $display("FAIL rr_adr[%0d]: adr=%h required %h", n, s0_adr, 32'h100 + 32'(idx));
      end
      s0_ack = 1'b1;
      #1;
      checks++;
      if (m_ack !== (4'b0001 << idx)) begin
        failures++; $display("FAIL rr_ack[%0d]: ack=%b required %b", n, m_ack, 4'b0001 << idx);
      end
      tick();
      s0_ack = 1'b0;
      own = idx;
      m_cyc[own] = 1'b0; m_stb[own] = 1'b0;
      #1;
      checks++;
      if (s0_cyc !== 1'b0) begin
        failures++; $display("FAIL rr_dead[%0d]: s0_cyc=%b required 0", n, s0_cyc);
      end
      tick();
      m_cyc[own] = 1'b1; m_stb[own] = 1'b1;
    end
    for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    tick();
  endtask

  task automatic test_lock();
    apply_reset();
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h200, 3'b010);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 3'b000);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
      exp_adr_q.push_back(32'h200 + 32'(4 * b));
      s0_ack = 1'b1;
      #1;
      checks++;
      if (grant !== 4'b0010 || s0_adr !== exp_adr_q.pop_front() || s0_cti !== ((b == 3) ? 3'b111 : 3'b010)
          || m_ack !== 4'b0010) begin
        failures++; $display("FAIL lock_beat[%0d]: grant=%b adr=%h cti=%b ack=%b required 0010/%h",
                             b, grant, s0_adr, s0_cti, m_ack, 32'h200 + 32'(4 * b));
      end
      tick();
    end
    s0_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checks++;
    if (grant !== 4'b0010 || s0_cyc !== 1'b0) begin
      failures++; $display("FAIL lock_handoff_dead: grant=%b s0_cyc=%b required 0010/0", grant, s0_cyc);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || s0_adr !== 32'h300) begin
      failures++; $display("FAIL lock_m0_grant: grant=%b adr=%h required 0001/300", grant, s0_adr);
    end
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h400, 3'b000);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 3'b000);
    for (int k = 1; k < TO; k++) begin
      #1;
      checks++;
      if (m_err !== 4'b0000 || timeout !== 1'b0 || grant !== 4'b1000) begin
        failures++; $display("FAIL to_early[%0d]: err=%b timeout=%b grant=%b required 0000/0/1000",
                             k, m_err, timeout, grant);
      end
      tick();
    end
    #1;
    checks++;
    if (m_err !== 4'b1000 || timeout !== 1'b1) begin
      failures++; $display("FAIL to_fire: err=%b timeout=%b required 1000/1", m_err, timeout);
    end
    tick();
    s0_ack = 1'b1;
    #1;
    checks++;
    if (s0_cyc !== 1'b0 || s0_stb !== 1'b0 || m_err !== 4'b0000 || timeout !== 1'b0) begin
      failures++; $display("FAIL to_abort: s0_cyc=%b stb=%b err=%b timeout=%b required 0/0/0000/0",
                           s0_cyc, s0_stb, m_err, timeout);
    end
    checks++;
    if (m_ack !== 4'b0000) begin
      failures++; $display("FAIL to_late_ack: ack=%b required 0000", m_ack);
    end
    tick();
    s0_ack = 1'b0;
    set_m(3, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    tick();
    checks++;
    if (grant !== 4'b0001 || s0_cyc !== 1'b1) begin
      failures++; $display("FAIL to_next_owner: grant=%b s0_cyc=%b required 0001/1", grant, s0_cyc);
    end
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h600, 3'b000);
    tick();
    s0_ack = 1'b1;
    #1;
    checks++;
    if (m_ack !== 4'b0010 || s0_cyc !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: ack=%b s0_cyc=%b required 0010/1", m_ack, s0_cyc);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (s0_cyc !== 1'b0 || grant !== 4'b0000 || m_ack !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_async: s0_cyc=%b grant=%b ack=%b required 0/0000/0000",
                           s0_cyc, grant, m_ack);
    end
    s0_ack = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h700, 3'b000);
    @(posedge clk);
    #3 rstn = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || s0_adr !== 32'h700) begin
      failures++; $display("FAIL rst_mid_priority: grant=%b adr=%h required 0001/700", grant, s0_adr);
    end
    for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
